dac_spi_tx: RTL and testbench
=============================

# dac_spi_tx

Serial DAC transmitter for the DDS waveform output. It takes the 12-bit sample produced by the waveform mux and shifts it out as a 16-bit SPI frame (4 config bits + sample) to an external MCP4921-class DAC. It then pulses LDAC to update the analog output. It sits between the waveform mux and the chip pins, and buffers one pending sample so a new sample can arrive while a frame is in flight.

## Interface
- `m`, 12: sample width; m ≤ 12, sample is left-justified in the 12-bit data field with zero LSB padding.
- `CLKDIV`, 2: SCK half-period in `clk` cycles (H); legal range 1..255.
- `CFG`, 4'b0011: frame bits [15:12]: A/B=0, BUF=0, GA=1 (1x), SHDN=1.
- `clk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `sample` input m: waveform sample from the mux.
- `sample_valid` input 1: single-cycle strobe, sample is new this cycle.
- `sck` output 1: SPI clock, mode 0 (idle low, data sampled by DAC on rising edge).
- `sdi` output 1: SPI data to DAC, MSB first.
- `cs_n` output 1: DAC chip select, active low.
- `ldac_n` output 1: DAC latch strobe, active low.
- `busy` output 1: high whenever state ≠ IDLE.
- `dropped` output 1: one-cycle pulse when a buffered sample is overwritten before transmission.

## Operation
- Reset values, all registered: `cs_n`=1, `sck`=0, `sdi`=0, `ldac_n`=1, `busy`=0, `dropped`=0. Pending buffer and its valid flag are cleared, state=IDLE, and both counters are 0.
- Frame word: {CFG, sample, (12−m) zeros}, 16 bits, loaded into a shift register at launch.
- States:
  - IDLE: `sample_valid` launches a frame and the state goes to SETUP.
  - SETUP: `cs_n`=0, `sdi`=frame[15], `sck`=0 for H cycles, then SHIFT.
  - SHIFT: 16 bits; each bit is H cycles `sck`=0 followed by H cycles `sck`=1. `sdi` changes only on the cycle `sck` falls; bit 15 is already on `sdi` when SHIFT begins. After the 16th high phase, `sck` goes 0 and the state goes to HOLD.
  - HOLD: `sck`=0, `cs_n`=0 for H cycles, then `cs_n`=1 and the state goes to LDAC.
  - LDAC: `ldac_n`=0 for H cycles, then `ldac_n`=1.
- Exit from LDAC:
  - If `sample_valid` is high this cycle, launch it; if the pending flag was also set, pulse `dropped`.
  - Else if the pending flag is set, launch the pending sample and clear the flag.
  - Else go to IDLE.
- Launching from LDAC enters SETUP directly with no IDLE cycle.
- Buffering: `sample_valid` in any state other than IDLE or the last LDAC cycle writes the pending register (latest wins). If the flag was already set, `dropped` pulses the same cycle.
- Counters:
  - Half-period counter, 8 bits, counts 0..CLKDIV−1 and wraps.
  - Bit counter, 5 bits, counts 0..15 and saturates until reloaded.
- A reset asserted mid-frame aborts at the next edge: all outputs go to their reset values with no partial LDAC. The DAC ignores the truncated frame because `cs_n` rises before 16 clocks.

## Timing
- Latency: `sample_valid` is sampled at edge E0. `cs_n` falls at E0 and `sdi`=frame[15] is valid from E0.
- First `sck` rise at E0+2H; the n-th rise (n=1..16) at E0+2nH.
- Last `sck` fall at E0+33H, `cs_n` rise at E0+34H.
- `ldac_n` is low for E0+34H..E0+35H.
- Next launch is possible at E0+35H.
- Frame period is 35H cycles; sustained rate is `clk`/(35·CLKDIV) samples/s.
- `sdi` is stable ≥ H cycles before and after each `sck` rise.
- `busy` rises at E0+1 and falls one cycle after LDAC completes if nothing is pending.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `sample_valid`=1 → every reset value above holds, no `cs_n` activity; after release, `busy` stays 0 until the next strobe.
- Single frame, CLKDIV=2, m=12, sample=0xABC → 16 bits captured on `sck` rises equal 0x3ABC; `cs_n` low for 68 cycles; `ldac_n` low for 2 cycles starting at cycle 68; `busy` drops at cycle 71.
- Pending and overwrite: strobe 0x111, then 0x222 at cycle 10, then 0x333 at cycle 20 → `dropped` pulses once at cycle 20; frames 0x3111 then 0x3333 go out back-to-back with no IDLE cycle; 0x222 is never sent.
- Boundary collision: pending=0x444, strobe 0x555 on the last LDAC cycle → `dropped` pulses and the next frame is 0x3555.
- Mid-frame reset: `rst_n` low at cycle 20 of a frame → at the next edge `cs_n`=1, `sck`=0, `ldac_n`=1; no LDAC pulse; a strobe after release gives a clean full frame.
- CLKDIV=1 and m=8 with sample=0xFF → frame 0x3FF0, 35-cycle period, and 16 `sck` rises each 2 cycles apart.

Source files
------------

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serial transmitter for an MCP4921-class DAC.
// Each accepted sample is shifted out as a 16-bit SPI frame {CFG, sample,
// zero pad}, MSB first, in SPI mode 0. LDAC is then pulsed low for one
// half-period. One sample can be buffered while a frame is in flight.
//
// Ports:
//   clk, rst_n     system clock, synchronous active-low reset
//   sample         m-bit waveform sample (left-justified into 12 bits)
//   sample_valid   single-cycle strobe qualifying sample
//   sck, sdi       SPI clock (idle low) and data to the DAC
//   cs_n, ldac_n   DAC chip select and output latch strobe (active low)
//   busy           high while a frame, hold or LDAC phase is in progress
//   dropped        one-cycle pulse when a buffered sample is discarded
module dac_spi_tx #(
  parameter int         m      = 12,
  parameter int         CLKDIV = 2,
  parameter logic [3:0] CFG    = 4'b0011
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [m-1:0] sample,
  input  logic         sample_valid,
  output logic         sck,
  output logic         sdi,
  output logic         cs_n,
  output logic         ldac_n,
  output logic         busy,
  output logic         dropped
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LDAC} state_t;

  state_t         state_q, state_d;
  logic [7:0]     hcnt_q, hcnt_d;
  logic [4:0]     bcnt_q, bcnt_d;
  logic [15:0]    shreg_q, shreg_d;
  logic [m-1:0]   pend_q, pend_d;
  logic           pend_vld_q, pend_vld_d;
  logic           sck_q, sck_d, sdi_q, sdi_d;
  logic           cs_n_q, cs_n_d, ldac_n_q, ldac_n_d;
  logic           busy_q, busy_d, dropped_q, dropped_d;

  logic           ph_end, last_ldac, launch;
  logic [m-1:0]   launch_s;
  logic [15:0]    launch_w;

  function automatic logic [15:0] frame_word(input logic [m-1:0] s);
    logic [11:0] d;
    d = 12'(s);
    d = d << (12 - m);
    return {CFG, d};
  endfunction

  assign ph_end    = (hcnt_q == 8'(CLKDIV - 1));
  assign last_ldac = (state_q == LDAC) && ph_end;

  always_comb begin
    state_d    = state_q;
    hcnt_d     = ph_end ? 8'd0 : hcnt_q + 8'd1;
    bcnt_d     = bcnt_q;
    shreg_d    = shreg_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    sck_d      = sck_q;
    sdi_d      = sdi_q;
    cs_n_d     = cs_n_q;
    ldac_n_d   = ldac_n_q;
    // busy follows the state with one cycle of lag (registered view)
    busy_d     = (state_q != IDLE);
    dropped_d  = 1'b0;
    launch     = 1'b0;
    launch_s   = sample;

    // Mid-frame strobes go to the single-entry buffer, latest wins.
    // The final LDAC cycle is excluded: there the strobe launches directly.
    if (sample_valid && state_q != IDLE && !last_ldac) begin
      pend_d     = sample;
      pend_vld_d = 1'b1;
      dropped_d  = pend_vld_q;
    end

    case (state_q)
      IDLE: begin
        hcnt_d = 8'd0;
        if (sample_valid) launch = 1'b1;
      end
      SETUP: begin
        if (ph_end) begin
          state_d = SHIFT;
          bcnt_d  = 5'd0;
        end
      end
      SHIFT: begin
        if (ph_end) begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            // falling edge: advance data so it is stable a full half-period
            // on both sides of the next rising edge
            sck_d   = 1'b0;
            shreg_d = shreg_q << 1;
            sdi_d   = shreg_q[14];
            if (bcnt_q == 5'd15) state_d = HOLD;
            else                 bcnt_d  = bcnt_q + 5'd1;
          end
        end
      end
      HOLD: begin
        if (ph_end) begin
          cs_n_d   = 1'b1;
          ldac_n_d = 1'b0;
          state_d  = LDAC;
        end
      end
      LDAC: begin
        if (ph_end) begin
          ldac_n_d = 1'b1;
          if (sample_valid) begin
            // fresh sample beats the buffered one
            launch     = 1'b1;
            dropped_d  = pend_vld_q;
            pend_vld_d = 1'b0;
          end else if (pend_vld_q) begin
            launch     = 1'b1;
            launch_s   = pend_q;
            pend_vld_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    launch_w = frame_word(launch_s);
    if (launch) begin
      state_d = SETUP;
      shreg_d = launch_w;
      sdi_d   = launch_w[15];
      cs_n_d  = 1'b0;
      sck_d   = 1'b0;
      hcnt_d  = 8'd0;
      bcnt_d  = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hcnt_q     <= 8'd0;
      bcnt_q     <= 5'd0;
      shreg_q    <= 16'd0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      sck_q      <= 1'b0;
      sdi_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      ldac_n_q   <= 1'b1;
      busy_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      sck_q      <= sck_d;
      sdi_q      <= sdi_d;
      cs_n_q     <= cs_n_d;
      ldac_n_q   <= ldac_n_d;
      busy_q     <= busy_d;
      dropped_q  <= dropped_d;
    end
  end

  assign sck     = sck_q;
  assign sdi     = sdi_q;
  assign cs_n    = cs_n_q;
  assign ldac_n  = ldac_n_q;
  assign busy    = busy_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: a 12-bit/CLKDIV=2 instance and an 8-bit/CLKDIV=1
// instance. Stimulus is scheduled per cycle; outputs are recorded on the
// falling clock edge and frames are rebuilt from sdi at each sck rise.
module tb_dac_spi_tx;
  localparam int MAXC = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [11:0] sample = '0;
  logic sv = 1'b0;
  logic [7:0] sample8 = '0;
  logic sv8 = 1'b0;
  logic sck, sdi, cs_n, ldac_n, busy, dropped;
  logic sck8, sdi8, cs_n8, ldac_n8, busy8, dropped8;

  always #5 clk = ~clk;

  dac_spi_tx #(.m(12), .CLKDIV(2), .CFG(4'b0011)) u_dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sv),
    .sck(sck), .sdi(sdi), .cs_n(cs_n), .ldac_n(ldac_n),
    .busy(busy), .dropped(dropped));

  dac_spi_tx #(.m(8), .CLKDIV(1), .CFG(4'b0011)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .sample(sample8), .sample_valid(sv8),
    .sck(sck8), .sdi(sdi8), .cs_n(cs_n8), .ldac_n(ldac_n8),
    .busy(busy8), .dropped(dropped8));

  int n_checks = 0;
  int n_err = 0;

  bit         sch_v[MAXC];
  logic [11:0] sch_s[MAXC];
  bit         sch_r[MAXC];
  bit         sch_v8[MAXC];
  logic [7:0] sch_s8[MAXC];

  bit o_csn[2][MAXC], o_sck[2][MAXC], o_sdi[2][MAXC];
  bit o_ldac[2][MAXC], o_busy[2][MAXC], o_drop[2][MAXC];

  int fr_word[$], fr_bits[$], fr_start[$], rise_c[$];

  typedef struct {
    logic [11:0] samp;
    logic [15:0] exp_frame;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clr_sched();
    for (int i = 0; i < MAXC; i++) begin
      sch_v[i] = 0; sch_s[i] = '0; sch_r[i] = 1;
      sch_v8[i] = 0; sch_s8[i] = '0;
    end
  endtask

  // Entry c of the schedule is sampled at edge c; obs[c] is the state
  // after edge c.
  task automatic observe(input int n);
    @(negedge clk);
    for (int c = 0; c < n; c++) begin
      rst_n = sch_r[c]; sv = sch_v[c]; sample = sch_s[c];
      sv8 = sch_v8[c]; sample8 = sch_s8[c];
      @(posedge clk);
      @(negedge clk);
      o_csn[0][c] = cs_n;   o_sck[0][c] = sck;   o_sdi[0][c] = sdi;
      o_ldac[0][c] = ldac_n; o_busy[0][c] = busy; o_drop[0][c] = dropped;
      o_csn[1][c] = cs_n8;  o_sck[1][c] = sck8;  o_sdi[1][c] = sdi8;
      o_ldac[1][c] = ldac_n8; o_busy[1][c] = busy8; o_drop[1][c] = dropped8;
    end
    sv = 0; sv8 = 0; rst_n = 1;
  endtask

  task automatic decode(input int d, input int n);
    logic [15:0] cur;
    int bits, st;
    bit pcs, psck;
    cur = '0; bits = 0; st = 0;
    fr_word.delete(); fr_bits.delete(); fr_start.delete(); rise_c.delete();
    for (int c = 0; c < n; c++) begin
      pcs  = (c == 0) ? 1'b1 : o_csn[d][c-1];
      psck = (c == 0) ? 1'b0 : o_sck[d][c-1];
      if (pcs && !o_csn[d][c]) begin cur = '0; bits = 0; st = c; end
      if (!o_csn[d][c] && o_sck[d][c] && !psck) begin
        cur = {cur[14:0], o_sdi[d][c]};
        bits++;
        rise_c.push_back(c);
      end
      if (!pcs && o_csn[d][c]) begin
        fr_word.push_back(int'(cur)); fr_bits.push_back(bits); fr_start.push_back(st);
      end
    end
  endtask

  function automatic int cnt_low_ldac(input int d, input int n);
    int k = 0;
    for (int c = 0; c < n; c++) if (!o_ldac[d][c]) k++;
    return k;
  endfunction

  function automatic int first_low_ldac(input int d, input int n);
    for (int c = 0; c < n; c++) if (!o_ldac[d][c]) return c;
    return -1;
  endfunction

  function automatic int cnt_low_csn(input int d, input int n);
    int k = 0;
    for (int c = 0; c < n; c++) if (!o_csn[d][c]) k++;
    return k;
  endfunction

  function automatic int cnt_drop(input int d, input int n);
    int k = 0;
    for (int c = 0; c < n; c++) if (o_drop[d][c]) k++;
    return k;
  endfunction

  function automatic int first_drop(input int d, input int n);
    for (int c = 0; c < n; c++) if (o_drop[d][c]) return c;
    return -1;
  endfunction

  vec_t vecs[4];

  initial begin
    int bad;
    vecs[0] = '{12'hABC, 16'h3ABC};
    vecs[1] = '{12'h000, 16'h3000};
    vecs[2] = '{12'hFFF, 16'h3FFF};
    vecs[3] = '{12'h5A5, 16'h35A5};

    // Reset held 3 cycles with strobes asserted.
    clr_sched();
    for (int i = 0; i < 3; i++) begin
      sch_r[i] = 0; sch_v[i] = 1; sch_s[i] = 12'hFFF;
      sch_v8[i] = 1; sch_s8[i] = 8'hFF;
    end
    observe(12);
    for (int c = 0; c < 3; c++) begin
      chk("rst_outs", {o_csn[0][c], o_sck[0][c], o_sdi[0][c], o_ldac[0][c],
                       o_busy[0][c], o_drop[0][c]}, 6'b100100);
      chk("rst_outs8", {o_csn[1][c], o_sck[1][c], o_sdi[1][c], o_ldac[1][c],
                        o_busy[1][c], o_drop[1][c]}, 6'b100100);
    end
    bad = 0;
    for (int c = 3; c < 12; c++) if (o_busy[0][c] || !o_csn[0][c]) bad++;
    chk("idle_after_rst", bad, 0);

    // Single frames, CLKDIV=2, m=12.
    foreach (vecs[v]) begin
      clr_sched();
      sch_v[0] = 1; sch_s[0] = vecs[v].samp;
      observe(80);
      decode(0, 80);
      chk("nframes", fr_word.size(), 1);
      chk("frame", qget(fr_word, 0), vecs[v].exp_frame);
      chk("bits", qget(fr_bits, 0), 16);
      chk("csn_low", cnt_low_csn(0, 80), 68);
      chk("ldac_first", first_low_ldac(0, 80), 68);
      chk("ldac_len", cnt_low_ldac(0, 80), 2);
      chk("busy_edges", {o_busy[0][0], o_busy[0][1], o_busy[0][70], o_busy[0][71]}, 4'b0110);
      chk("nrises", rise_c.size(), 16);
      bad = 0;
      for (int i = 0; i < 16; i++) if (qget(rise_c, i) != 4 * (i + 1)) bad++;
      chk("rise_pos", bad, 0);
      chk("no_drop", cnt_drop(0, 80), 0);
    end

    // Pending buffer and overwrite.
    clr_sched();
    sch_v[0] = 1;  sch_s[0] = 12'h111;
    sch_v[10] = 1; sch_s[10] = 12'h222;
    sch_v[20] = 1; sch_s[20] = 12'h333;
    observe(150);
    decode(0, 150);
    chk("pend_nframes", fr_word.size(), 2);
    chk("pend_f0", qget(fr_word, 0), 16'h3111);
    chk("pend_f1", qget(fr_word, 1), 16'h3333);
    chk("pend_f1_bits", qget(fr_bits, 1), 16);
    chk("pend_f1_start", qget(fr_start, 1), 70);
    chk("pend_ndrop", cnt_drop(0, 150), 1);
    chk("pend_drop_at", first_drop(0, 150), 20);
    bad = 0;
    for (int c = 1; c <= 140; c++) if (!o_busy[0][c]) bad++;
    chk("pend_no_idle", bad, 0);
    chk("pend_busy_fall", o_busy[0][141], 0);

    // Strobe on the final LDAC cycle while a sample is pending.
    clr_sched();
    sch_v[0] = 1;  sch_s[0] = 12'h100;
    sch_v[10] = 1; sch_s[10] = 12'h444;
    sch_v[70] = 1; sch_s[70] = 12'h555;
    observe(150);
    decode(0, 150);
    chk("coll_nframes", fr_word.size(), 2);
    chk("coll_f0", qget(fr_word, 0), 16'h3100);
    chk("coll_f1", qget(fr_word, 1), 16'h3555);
    chk("coll_f1_start", qget(fr_start, 1), 70);
    chk("coll_ndrop", cnt_drop(0, 150), 1);
    chk("coll_drop_at", first_drop(0, 150), 70);

    // Reset mid-frame, then a clean frame.
    clr_sched();
    sch_v[0] = 1;  sch_s[0] = 12'hABC;
    sch_r[20] = 0;
    sch_v[30] = 1; sch_s[30] = 12'h123;
    observe(110);
    decode(0, 110);
    chk("mrst_pre_csn", o_csn[0][19], 0);
    chk("mrst_outs", {o_csn[0][20], o_sck[0][20], o_ldac[0][20], o_busy[0][20]}, 4'b1010);
    chk("mrst_nframes", fr_word.size(), 2);
    chk("mrst_trunc_bits", qget(fr_bits, 0), 4);
    chk("mrst_f1", qget(fr_word, 1), 16'h3123);
    chk("mrst_f1_bits", qget(fr_bits, 1), 16);
    chk("mrst_f1_start", qget(fr_start, 1), 30);
    chk("mrst_ldac_first", first_low_ldac(0, 110), 98);
    chk("mrst_ldac_len", cnt_low_ldac(0, 110), 2);

    // CLKDIV=1, m=8: back-to-back frames via the buffer.
    clr_sched();
    sch_v8[0] = 1; sch_s8[0] = 8'hFF;
    sch_v8[1] = 1; sch_s8[1] = 8'h0F;
    observe(80);
    decode(1, 80);
    chk("d8_nframes", fr_word.size(), 2);
    chk("d8_f0", qget(fr_word, 0), 16'h3FF0);
    chk("d8_f1", qget(fr_word, 1), 16'h30F0);
    chk("d8_f1_start", qget(fr_start, 1), 35);
    chk("d8_csn_low", cnt_low_csn(1, 80), 68);
    chk("d8_ldac_first", first_low_ldac(1, 80), 34);
    chk("d8_ldac_len", cnt_low_ldac(1, 80), 2);
    chk("d8_nrises", rise_c.size(), 32);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (qget(rise_c, i) != 2 * (i + 1)) bad++;
      if (qget(rise_c, 16 + i) != 35 + 2 * (i + 1)) bad++;
    end
    chk("d8_rise_pos", bad, 0);
    chk("d8_no_drop", cnt_drop(1, 80), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
